// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - op encoder feeding a 4-deep write FIFO into instruction memory
module instr_encoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [9:0]  BaseAddr,
    input  logic        InValid,
    output logic        InReady,
    input  logic [3:0]  Op,
    input  logic [2:0]  Rd,
    input  logic [2:0]  Rs,
    input  logic [4:0]  Imm,
    input  logic        Flag,
    input  logic [1:0]  PcSel,
    output logic        ProgWrEn,
    input  logic        WrReady,
    output logic [9:0]  ProgAddr,
    output logic [8:0]  ProgData,
    output logic [10:0] Count,
    output logic        Done,
    output logic        ErrIllegal,
    output logic        ErrOvf
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    localparam logic [8:0] HALT_WORD = 9'h1FF;

    state_t      state_q, state_d;
    logic [8:0]  mem_q [4];
    logic [8:0]  mem_d [4];
    logic [1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [2:0]  occ_q, occ_d;
    logic [9:0]  ptr_q, ptr_d;
    logic [10:0] count_q, count_d;
    logic        ill_q, ill_d, ovf_q, ovf_d;

    logic [8:0]  enc_word;
    logic        enc_legal;
    logic [8:0]  head;
    logic        in_ready, wr_en, accept, push, pop;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (Op)
            4'd0:  enc_word = {3'b000, Rd, Rs};
            4'd1:  enc_word = {3'b001, Rd, Rs};
            4'd2:  enc_word = {5'b01000, Rd, 1'b0};
            4'd3:  enc_word = {5'b01001, Rs, 1'b0};
            4'd4:  enc_word = {4'b0110, Rd, 2'b00};
            4'd5:  enc_word = {4'b0111, Rd, 2'b00};
            4'd6:  enc_word = {4'b1000, Flag, PcSel, 2'b00};
            4'd7:  enc_word = {4'b1001, PcSel, Flag, 2'b00};
            4'd8:  enc_word = {4'b1010, Rs, Flag, 1'b0};
            4'd9:  enc_word = {4'b1100, Rd, 2'b00};
            4'd10: begin
                enc_word  = {4'b1101, Rd, Rs[1:0]};
                enc_legal = Rs[2];
            end
            4'd11: enc_word = {4'b1110, Rd, Flag, 1'b0};
            // MOV #31 would collide with the HALT word
            4'd12: begin
                enc_word  = {4'b1111, Imm};
                enc_legal = (Imm != 5'd31);
            end
            4'd13: enc_word = HALT_WORD;
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        head     = mem_q[rd_q];
        in_ready = (state_q == S_LOAD) && (occ_q != 3'd4);
        wr_en    = (occ_q != 3'd0) && ((state_q == S_LOAD) || (state_q == S_DRAIN));
        accept   = InValid && in_ready;
        push     = accept && enc_legal;
        pop      = wr_en && WrReady;
    end

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        occ_d   = occ_q + {2'b00, push} - {2'b00, pop};
        ptr_d   = ptr_q;
        count_d = count_q;
        ill_d   = ill_q;
        ovf_d   = ovf_q;

        if (push) begin
            mem_d[wr_q] = enc_word;
            wr_d        = wr_q + 2'd1;
        end
        if (accept && !enc_legal) ill_d = 1'b1;
        if (accept && (Op == 4'd13)) state_d = S_DRAIN;

        if (pop) begin
            rd_d    = rd_q + 2'd1;
            count_d = count_q + 11'd1;
            if (ptr_q != 10'h3FF) ptr_d = ptr_q + 10'd1;
            if (head == HALT_WORD) begin
                state_d = S_DONE;
            end else if (ptr_q == 10'h3FF) begin
                // last address consumed by a non-HALT word: abandon the session
                ovf_d   = 1'b1;
                rd_d    = '0;
                wr_d    = '0;
                occ_d   = '0;
                state_d = S_DONE;
            end
        end

        if (Start && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
            state_d = S_LOAD;
            ptr_d   = BaseAddr;
            count_d = '0;
            ill_d   = 1'b0;
            ovf_d   = 1'b0;
            rd_d    = '0;
            wr_d    = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            occ_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            occ_q   <= occ_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    assign InReady    = in_ready;
    assign ProgWrEn   = wr_en;
    assign ProgAddr   = ptr_q;
    assign ProgData   = wr_en ? head : 9'd0;
    assign Count      = count_q;
    assign Done       = (state_q == S_DONE);
    assign ErrIllegal = ill_q;
    assign ErrOvf     = ovf_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed checks of instr_encoder against a queue model
module tb_instr_encoder;
    logic        Clk = 1'b0;
    logic        Reset, Start, InValid, Flag, WrReady;
    logic [9:0]  BaseAddr;
    logic [3:0]  Op;
    logic [2:0]  Rd, Rs;
    logic [4:0]  Imm;
    logic [1:0]  PcSel;
    logic        InReady, ProgWrEn, Done, ErrIllegal, ErrOvf;
    logic [9:0]  ProgAddr;
    logic [8:0]  ProgData;
    logic [10:0] Count;

    instr_encoder dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr),
        .InValid(InValid), .InReady(InReady), .Op(Op), .Rd(Rd), .Rs(Rs),
        .Imm(Imm), .Flag(Flag), .PcSel(PcSel), .ProgWrEn(ProgWrEn),
        .WrReady(WrReady), .ProgAddr(ProgAddr), .ProgData(ProgData),
        .Count(Count), .Done(Done), .ErrIllegal(ErrIllegal), .ErrOvf(ErrOvf)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    // model: session flags plus a plain queue of pending words
    bit m_sess, m_halt, m_done, m_ill, m_ovf;
    int m_ptr, m_count;
    int m_q[$];
    int wa[$];
    int wd[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int enc(input int op, input int rd, input int rs,
                               input int imm, input int flag, input int pcsel);
        case (op)
            0:  return (rd << 3) | rs;
            1:  return 64 | (rd << 3) | rs;
            2:  return 128 | (rd << 1);
            3:  return 144 | (rs << 1);
            4:  return 192 | (rd << 2);
            5:  return 224 | (rd << 2);
            6:  return 256 | (flag << 4) | (pcsel << 2);
            7:  return 288 | (pcsel << 3) | (flag << 2);
            8:  return 320 | (rs << 2) | (flag << 1);
            9:  return 384 | (rd << 2);
            10: return (rs < 4) ? -1 : (416 | (rd << 2) | (rs & 3));
            11: return 448 | (rd << 2) | (flag << 1);
            12: return (imm == 31) ? -1 : (480 | imm);
            13: return 511;
            default: return -1;
        endcase
    endfunction

    function automatic bit m_inready();
        return m_sess && !m_halt && (m_q.size() < 4);
    endfunction

    function automatic bit m_wren();
        return m_sess && (m_q.size() > 0);
    endfunction

    task automatic model_step();
        bit acc, wr, flushed;
        int w, e;
        if (Reset) begin
            m_sess = 0; m_halt = 0; m_done = 0; m_ill = 0; m_ovf = 0;
            m_ptr = 0; m_count = 0; m_q.delete();
            return;
        end
        if (!m_sess) begin
            if (Start) begin
                m_sess = 1; m_halt = 0; m_done = 0; m_ill = 0; m_ovf = 0;
                m_ptr = int'(BaseAddr); m_count = 0; m_q.delete();
            end
            return;
        end
        acc = InValid && m_inready();
        wr = m_wren() && WrReady;
        flushed = 0;
        if (wr) begin
            w = m_q.pop_front();
            m_count++;
            if (w == 511) begin
                m_sess = 0; m_done = 1;
            end else if (m_ptr == 1023) begin
                m_ovf = 1; m_q.delete(); m_sess = 0; m_done = 1; flushed = 1;
            end
            if (m_ptr < 1023) m_ptr++;
        end
        if (acc) begin
            e = enc(int'(Op), int'(Rd), int'(Rs), int'(Imm), int'(Flag), int'(PcSel));
            if (e < 0) m_ill = 1;
            else if (!flushed) begin
                m_q.push_back(e);
                if (Op == 4'd13) m_halt = 1;
            end
        end
    endtask

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("InReady", int'(InReady), int'(m_inready()));
            chk("ProgWrEn", int'(ProgWrEn), int'(m_wren()));
            chk("ProgAddr", int'(ProgAddr), m_ptr);
            chk("Count", int'(Count), m_count);
            chk("Done", int'(Done), int'(m_done));
            chk("ErrIllegal", int'(ErrIllegal), int'(m_ill));
            chk("ErrOvf", int'(ErrOvf), int'(m_ovf));
            if (m_wren()) chk("ProgData", int'(ProgData), m_q[0]);
        end
    end

    // inputs are set at negedge+1; this logs the DUT write about to complete, steps the model, and advances
    task automatic cyc();
        if (!Reset && ProgWrEn && WrReady) begin
            wa.push_back(int'(ProgAddr));
            wd.push_back(int'(ProgData));
        end
        model_step();
        @(negedge Clk);
        #1;
    endtask

    task automatic set_op(input int op, input int rd, input int rs, input int imm,
                          input int flag, input int pcsel);
        Op = 4'(op); Rd = 3'(rd); Rs = 3'(rs); Imm = 5'(imm); Flag = 1'(flag); PcSel = 2'(pcsel);
    endtask

    task automatic send_op(input int op, input int rd, input int rs, input int imm,
                           input int flag, input int pcsel, input int budget, output bit ok);
        set_op(op, rd, rs, imm, flag, pcsel);
        InValid = 1;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            ok = InReady;
            cyc();
        end
        InValid = 0;
    endtask

    task automatic start_session(input int base);
        Start = 1;
        BaseAddr = 10'(base);
        wa.delete();
        wd.delete();
        cyc();
        Start = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !Done; i++) cyc();
        chk("done_wait", int'(Done), 1);
    endtask

    bit ok;
    int idx;

    initial begin
        Reset = 1; Start = 0; InValid = 0; WrReady = 0; BaseAddr = '0;
        set_op(0, 0, 0, 0, 0, 0);
        #1;
        cyc();
        cmp_en = 1;
        cyc();
        Reset = 0;
        chk("rst_InReady", int'(InReady), 0);
        chk("rst_ProgWrEn", int'(ProgWrEn), 0);
        chk("rst_ProgAddr", int'(ProgAddr), 0);
        chk("rst_ProgData", int'(ProgData), 0);
        chk("rst_Count", int'(Count), 0);
        chk("rst_Done", int'(Done), 0);

        chk("enc_mov5", enc(12, 0, 0, 5, 0, 0), 485);
        chk("enc_add", enc(11, 1, 0, 0, 1, 0), 454);
        chk("enc_lsl", enc(0, 2, 5, 0, 0, 0), 21);
        chk("enc_spc", enc(7, 0, 0, 0, 1, 2), 308);
        chk("enc_orr_bad", enc(10, 1, 3, 0, 0, 0), -1);

        // basic session
        WrReady = 1;
        start_session(0);
        send_op(12, 0, 0, 5, 0, 0, 5, ok);
        send_op(11, 1, 0, 0, 1, 0, 5, ok);
        send_op(13, 0, 0, 0, 0, 0, 5, ok);
        wait_done(20);
        chk("t1_nwr", wa.size(), 3);
        if (wa.size() == 3) begin
            chk("t1_a0", wa[0], 0); chk("t1_d0", wd[0], 485);
            chk("t1_a1", wa[1], 1); chk("t1_d1", wd[1], 454);
            chk("t1_a2", wa[2], 2); chk("t1_d2", wd[2], 511);
        end
        chk("t1_count", int'(Count), 3);

        // backpressure: only four ops fit while writes stall
        WrReady = 0;
        start_session(100);
        idx = 0;
        InValid = 1;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) set_op(idx, (idx * 3 + 1) % 8, (idx * 5 + 2) % 8, 0, 0, 0);
            ok = InReady;
            cyc();
            if (ok) idx++;
        end
        InValid = 0;
        chk("t2_accepted", idx, 4);
        chk("t2_InReady", int'(InReady), 0);
        chk("t2_ProgAddr", int'(ProgAddr), 100);
        chk("t2_ProgData", int'(ProgData), 10);
        WrReady = 1;
        for (int k = 4; k < 6; k++) send_op(k, (k * 3 + 1) % 8, (k * 5 + 2) % 8, 0, 0, 0, 10, ok);
        send_op(13, 0, 0, 0, 0, 0, 10, ok);
        wait_done(20);
        chk("t2_nwr", wa.size(), 7);
        if (wa.size() == 7) begin
            for (int k = 0; k < 6; k++) begin
                chk("t2_addr", wa[k], 100 + k);
                chk("t2_data", wd[k], enc(k, (k * 3 + 1) % 8, (k * 5 + 2) % 8, 0, 0, 0));
            end
            chk("t2_halt", wd[6], 511);
        end

        // illegal ops are swallowed
        start_session(50);
        send_op(14, 0, 0, 0, 0, 0, 5, ok);
        send_op(10, 1, 3, 0, 0, 0, 5, ok);
        send_op(12, 0, 0, 31, 0, 0, 5, ok);
        send_op(0, 2, 5, 0, 0, 0, 5, ok);
        send_op(13, 0, 0, 0, 0, 0, 5, ok);
        wait_done(20);
        chk("t3_ill", int'(ErrIllegal), 1);
        chk("t3_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("t3_d0", wd[0], 21); chk("t3_a0", wa[0], 50);
            chk("t3_d1", wd[1], 511);
        end

        // address overflow
        start_session(1022);
        send_op(1, 1, 2, 0, 0, 0, 5, ok);
        send_op(4, 3, 0, 0, 0, 0, 5, ok);
        send_op(9, 4, 0, 0, 0, 0, 5, ok);
        send_op(13, 0, 0, 0, 0, 0, 3, ok);
        for (int i = 0; i < 5; i++) cyc();
        chk("t4_ovf", int'(ErrOvf), 1);
        chk("t4_done", int'(Done), 1);
        chk("t4_addr", int'(ProgAddr), 1023);
        chk("t4_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("t4_a0", wa[0], 1022); chk("t4_d0", wd[0], 74);
            chk("t4_a1", wa[1], 1023); chk("t4_d1", wd[1], 204);
        end

        // reset mid-session, ignored Start, restart from DONE
        WrReady = 0;
        start_session(10);
        send_op(2, 1, 0, 0, 0, 0, 5, ok);
        send_op(3, 0, 2, 0, 0, 0, 5, ok);
        send_op(4, 3, 0, 0, 0, 0, 5, ok);
        Reset = 1; WrReady = 1; InValid = 1;
        cyc();
        Reset = 0; InValid = 0;
        chk("t5_InReady", int'(InReady), 0);
        chk("t5_ProgWrEn", int'(ProgWrEn), 0);
        chk("t5_ProgAddr", int'(ProgAddr), 0);
        chk("t5_ProgData", int'(ProgData), 0);
        chk("t5_Count", int'(Count), 0);
        WrReady = 0;
        start_session(10);
        send_op(15, 0, 0, 0, 0, 0, 5, ok);
        Start = 1; BaseAddr = 10'd500;
        cyc();
        Start = 0;
        chk("t5_ign_addr", int'(ProgAddr), 10);
        WrReady = 1;
        send_op(13, 0, 0, 0, 0, 0, 5, ok);
        wait_done(10);
        chk("t5_ill", int'(ErrIllegal), 1);
        chk("t5_addr", int'(ProgAddr), 11);
        start_session(300);
        chk("t5_re_ill", int'(ErrIllegal), 0);
        chk("t5_re_done", int'(Done), 0);
        chk("t5_re_addr", int'(ProgAddr), 300);
        chk("t5_re_rdy", int'(InReady), 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_op($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 3));
            InValid = ($urandom_range(0, 3) != 0);
            WrReady = ($urandom_range(0, 3) != 0);
            Start = m_sess ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 5) == 0);
            BaseAddr = $urandom_range(0, 1) ? 10'($urandom_range(1010, 1023)) : 10'($urandom_range(0, 1023));
            Reset = ($urandom_range(0, 299) == 0);
            cyc();
        end
        Reset = 0; Start = 0; InValid = 0; WrReady = 0;
        cyc();
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Clk  in  1  sole clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high; sampled on rising Clk.
REQ-003 Start  in  1  one-cycle pulse; begins a load session at BaseAddr.
REQ-004 BaseAddr  in  10  first instruction-memory address of the session.
REQ-005 InValid / InReady  in / out  1 / 1  op handshake; transfer when both high on an edge.
REQ-006 Op  in  4  0 LSL, 1 LSR, 2 LDR, 3 STR, 4 XOR, 5 RXR, 6 JMP, 7 SPC, 8 LUT, 9 CPY, 10 ORR, 11 ADD, 12 MOV, 13 HALT, 14-15 illegal.
REQ-007 Rd, Rs  in  3 each  register fields.
REQ-008 Imm  in  5  MOV immediate.
REQ-009 Flag  in  1  JMP: 1=jne; SPC: offset enable; LUT: 1=MSW; ADD: 1=subtract.
REQ-010 PcSel  in  2  PC register select for JMP/SPC.
REQ-011 ProgWrEn / WrReady  out / in  1 / 1  instruction-memory write handshake.
REQ-012 ProgAddr  out  10; ProgData  out  9  write address and machine word.
REQ-013 Count  out  11  words written this session.
REQ-014 Done  out  1; ErrIllegal  out  1; ErrOvf  out  1  status, sticky until Start or Reset.

Function
REQ-015 Encoding, ProgData[8:0]: LSL 000,Rd,Rs; LSR 001,Rd,Rs; LDR 01000,Rd,0; STR 01001,Rs,0; XOR 0110,Rd,00; RXR 0111,Rd,00; JMP 1000,Flag,PcSel,00; SPC 1001,PcSel,Flag,00; LUT 1010,Rs,Flag,0; CPY 1100,Rd,00; ORR 1101,Rd,Rs[1:0]; ADD 1110,Rd,Flag,0; MOV 1111,Imm; HALT 111111111.
REQ-016 Illegal ops: Op 14/15, ORR with Rs[2]=0, MOV with Imm=31 (aliases HALT); accepted (handshake completes), not enqueued, ErrIllegal set next edge.
REQ-017 States IDLE, LOAD, DRAIN, DONE; Reset -> IDLE.
REQ-018 IDLE: Start -> LOAD; address pointer <= BaseAddr; Count, Done, ErrIllegal, ErrOvf cleared; FIFO emptied.
REQ-019 LOAD: InReady = FIFO occupancy < 4; legal accepted op encoded and pushed at the accepting edge (1-cycle latency to FIFO head).
REQ-020 LOAD: accepted HALT pushed, then -> DRAIN; InReady low in DRAIN and DONE.
REQ-021 FIFO depth 4, in-order; push and pop in the same cycle permitted when not full; no push when full.
REQ-022 ProgWrEn = FIFO non-empty and state in LOAD or DRAIN; ProgData = head word; ProgAddr = pointer; all held stable while WrReady low.
REQ-023 Write completes on ProgWrEn and WrReady: pop, pointer +1, Count +1.
REQ-024 DRAIN: completed write of the HALT word -> DONE; Done = 1.
REQ-025 Overflow: non-HALT write completing at ProgAddr 1023 -> ErrOvf = 1, FIFO flushed, -> DONE, Done = 1; pointer never wraps.
REQ-026 Start in LOAD or DRAIN ignored; Start in DONE behaves as in IDLE.
REQ-027 Start coincident with InValid in IDLE/DONE: op not accepted that cycle (InReady low).

Reset
REQ-028 On Reset: state IDLE, FIFO empty, InReady 0, ProgWrEn 0, ProgAddr 0, ProgData 0, Count 0, Done 0, ErrIllegal 0, ErrOvf 0.
REQ-029 Reset mid-session overrides all traffic; no write completes in the Reset cycle; pending FIFO entries discarded.

Verification
REQ-030 Start BaseAddr=0; ops MOV Imm=5, ADD Rd=1 Flag=1, HALT, WrReady=1 -> writes 0:111100101, 1:111000110, 2:111111111; Count=3; Done=1.
REQ-031 WrReady=0 for 10 cycles, 6 ops offered -> exactly 4 accepted, InReady=0, ProgAddr/ProgData stable; WrReady=1 -> remaining ops accepted, writes in order.
REQ-032 Op=14, then ORR Rs=3, then MOV Imm=31, then LSL Rd=2 Rs=5, HALT -> ErrIllegal=1; only 000010101 and 111111111 written.
REQ-033 BaseAddr=1022; LSR, XOR, CPY, HALT -> writes at 1022,1023; ErrOvf=1; Done=1; nothing further written.
REQ-034 Reset asserted with 3 words queued and WrReady=0 -> next cycle all outputs at reset values; Start in LOAD shown ignored; Start in DONE restarts session with cleared status.
